capp_response_resolver: RTL and testbench

CAPP_RESPONSE_RESOLVER -- requirements
Module: capp_response_resolver

---
 rtl/capp_response_resolver.sv | 124 ++++++++++++
 tb/tb_capp_response_resolver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/capp_response_resolver.sv
// Enumerates CAPP match tags lowest-index first through a valid/ready response port.
// Optional macro CAPP_RESP_COUNT_EN adds the registered resp_count output.
module capp_response_resolver #(
    parameter int NUM_WORDS = 32,
    parameter int IDX_W     = 5
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_WORDS-1:0] tags_in,
    input  logic                 tags_valid,
    input  logic                 clear,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDX_W-1:0]     resp_index,
    output logic                 some_resp,
    output logic                 search_done
`ifdef CAPP_RESP_COUNT_EN
    ,
    output logic [IDX_W:0]       resp_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_WORDS-1:0]   tags_q, tags_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic                   some_q, some_d;
    logic                   done_q, done_d;
    logic [NUM_WORDS-1:0]   consume_mask;
    logic                   handshake;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_WORDS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_WORDS - 1; i >= 0; i--) begin
            if (v[i]) idx = i[IDX_W-1:0];
        end
        return idx;
    endfunction

    // Handshake: a transfer happens on a rising edge where resp_valid and
    // resp_ready are both high; resp_valid/resp_index never change while
    // resp_valid is high and resp_ready is low. resp_ready is ignored in IDLE.
    assign handshake    = (state_q == BUSY) && resp_ready;
    assign consume_mask = {{(NUM_WORDS-1){1'b0}}, 1'b1} << index_q;

    // Priority: clear, then a new tag load, then consumption of the presented index.
    always_comb begin
        tags_d = tags_q;
        done_d = 1'b0;
        if (clear) begin
            tags_d = '0;
        end else if (tags_valid) begin
            tags_d = tags_in;
            done_d = ~|tags_in;
        end else if (handshake) begin
            tags_d = tags_q & ~consume_mask;
            done_d = ~|(tags_q & ~consume_mask);
        end
        state_d = (|tags_d) ? BUSY : IDLE;
        index_d = lowest_set(tags_d);
        some_d  = |tags_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            tags_q  <= '0;
            index_q <= '0;
            some_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tags_q  <= tags_d;
            index_q <= index_d;
            some_q  <= some_d;
            done_q  <= done_d;
        end
    end

    assign resp_valid  = (state_q == BUSY);
    assign resp_index  = index_q;
    assign some_resp   = some_q;
    assign search_done = done_q;

`ifdef CAPP_RESP_COUNT_EN
    logic [IDX_W:0] count_q, count_d;

    function automatic logic [IDX_W:0] popcount(input logic [NUM_WORDS-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tags_valid) begin
            count_d = popcount(tags_in);
        end else if (handshake) begin
            count_d = count_q - {{IDX_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign resp_count = count_q;
`endif

endmodule

// File: tb/tb_capp_response_resolver.sv
// Self-checking bench for capp_response_resolver: vector table, hand sequences, random scoreboard.
module tb_capp_response_resolver;
  localparam int W = 14;

  logic        CLK;
  logic        RST_N;
  logic [31:0] tags_in;
  logic        tags_valid;
  logic        clear;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_index;
  logic        some_resp;
  logic        search_done;
  logic [5:0]  cnt_act;

`ifdef CAPP_RESP_COUNT_EN
  logic [5:0] resp_count;
  assign cnt_act = resp_count;
`else
  assign cnt_act = 6'd0;
`endif

  capp_response_resolver #(.NUM_WORDS(32), .IDX_W(5)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .tags_in     (tags_in),
    .tags_valid  (tags_valid),
    .clear       (clear),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_index  (resp_index),
    .some_resp   (some_resp),
    .search_done (search_done)
`ifdef CAPP_RESP_COUNT_EN
    ,
    .resp_count  (resp_count)
`endif
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [W-1:0] mk(input logic v, input logic [4:0] i, input logic s,
                                      input logic d, input logic [5:0] c);
`ifdef CAPP_RESP_COUNT_EN
    return {v, i, s, d, c};
`else
    return {v, i, s, d, c & 6'd0};
`endif
  endfunction

  task automatic pop_check(input string name);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {resp_valid, resp_index, some_resp, search_done, cnt_act};
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got valid=%0b idx=%0d", name, resp_valid, resp_index);
    end else begin
      exp = exp_q.pop_front();
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got valid=%0b idx=%0d some=%0b done=%0b cnt=%0d, want valid=%0b idx=%0d some=%0b done=%0b cnt=%0d",
                 name, act[13], act[12:8], act[7], act[6], act[5:0],
                 exp[13], exp[12:8], exp[7], exp[6], exp[5:0]);
      end
    end
  endtask

  // driver: apply inputs for one cycle, push expectation, compare after the edge
  task automatic step(input string name, input logic [31:0] t, input logic tv, input logic rdy,
                      input logic clr, input logic [W-1:0] exp);
    tags_in    = t;
    tags_valid = tv;
    resp_ready = rdy;
    clear      = clr;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    pop_check(name);
  endtask

  typedef struct {
    logic [31:0] tags;
    logic        tv;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [4:0]  ei;
    logic        es;
    logic        ed;
    logic [5:0]  ec;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  logic [31:0] model_tags;
  logic [31:0] nxt;
  logic [31:0] rt;
  logic        rtv, rrdy, rclr, rdone;
  logic [4:0]  ridx;

  initial begin
    // 0x8000_0011 with ready held high: 0, 4, 31, then done
    vecs[0]  = '{32'h8000_0011, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 6'd3};
    vecs[1]  = '{32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 6'd2};
    vecs[2]  = '{32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 6'd1};
    vecs[3]  = '{32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 6'd0};
    vecs[4]  = '{32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'd0};
    // all-zero load: no-match completion
    vecs[5]  = '{32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 6'd0};
    vecs[6]  = '{32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'd0};
    // 0x6 with ready low for 3 cycles
    vecs[7]  = '{32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  1'b1, 1'b0, 6'd2};
    vecs[8]  = '{32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b1, 1'b0, 6'd2};
    vecs[9]  = '{32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b1, 1'b0, 6'd2};
    vecs[10] = '{32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b1, 1'b0, 6'd2};
    vecs[11] = '{32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  1'b1, 1'b0, 6'd1};
    vecs[12] = '{32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 6'd0};
    vecs[13] = '{32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'd0};
    // handshake together with a new load of 0x100
    vecs[14] = '{32'h0000_0003, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 6'd2};
    vecs[15] = '{32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 6'd1};
    vecs[16] = '{32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 6'd0};
    vecs[17] = '{32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'd0};
    // clear beats a simultaneous load and handshake
    vecs[18] = '{32'h0000_00F0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 6'd4};
    vecs[19] = '{32'h0000_00FF, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 6'd0};
    vecs[20] = '{32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'd0};

    RST_N      = 1'b0;
    tags_in    = '0;
    tags_valid = 1'b0;
    resp_ready = 1'b0;
    clear      = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    exp_q.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 6'd0));
    pop_check("reset_state");
    RST_N = 1'b1;

    for (int k = 0; k < NV; k++) begin
      step($sformatf("vec%0d", k), vecs[k].tags, vecs[k].tv, vecs[k].rdy, vecs[k].clr,
           mk(vecs[k].ev, vecs[k].ei, vecs[k].es, vecs[k].ed, vecs[k].ec));
    end

    // clear mid-enumeration of all-ones
    step("ones_load",  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, mk(1'b1, 5'd0, 1'b1, 1'b0, 6'd32));
    step("ones_hs0",   32'h0,         1'b0, 1'b1, 1'b0, mk(1'b1, 5'd1, 1'b1, 1'b0, 6'd31));
    step("ones_hs1",   32'h0,         1'b0, 1'b1, 1'b0, mk(1'b1, 5'd2, 1'b1, 1'b0, 6'd30));
    step("ones_clear", 32'h0,         1'b0, 1'b1, 1'b1, mk(1'b0, 5'd0, 1'b0, 1'b0, 6'd0));
    step("after_clr",  32'h0,         1'b0, 1'b1, 1'b0, mk(1'b0, 5'd0, 1'b0, 1'b0, 6'd0));

    // asynchronous reset mid-enumeration
    step("ones_load2", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, mk(1'b1, 5'd0, 1'b1, 1'b0, 6'd32));
    step("ones_hs2",   32'h0,         1'b0, 1'b1, 1'b0, mk(1'b1, 5'd1, 1'b1, 1'b0, 6'd31));
    resp_ready = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    exp_q.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 6'd0));
    pop_check("async_rst");
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step("post_rst0",  32'h0, 1'b0, 1'b1, 1'b0, mk(1'b0, 5'd0, 1'b0, 1'b0, 6'd0));
    step("post_rst1",  32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 5'd0, 1'b0, 1'b0, 6'd0));
    step("load_one",   32'h1, 1'b1, 1'b0, 1'b0, mk(1'b1, 5'd0, 1'b1, 1'b0, 6'd1));
    step("one_done",   32'h0, 1'b0, 1'b1, 1'b0, mk(1'b0, 5'd0, 1'b0, 1'b1, 6'd0));
    step("one_idle",   32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 5'd0, 1'b0, 1'b0, 6'd0));

    // random traffic against a behavioural model
    model_tags = '0;
    for (int n = 0; n < 300; n++) begin
      rtv  = ($urandom_range(0, 5) == 0) || (model_tags == 0 && $urandom_range(0, 1) == 1);
      rt   = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      rrdy = $urandom_range(0, 2) != 0;
      rclr = $urandom_range(0, 39) == 0;
      if (rclr) begin
        nxt   = '0;
        rdone = 1'b0;
      end else if (rtv) begin
        nxt   = rt;
        rdone = (rt == 0);
      end else if (model_tags != 0 && rrdy) begin
        nxt   = model_tags & (model_tags - 32'd1);
        rdone = (nxt == 0);
      end else begin
        nxt   = model_tags;
        rdone = 1'b0;
      end
      ridx = '0;
      for (int b = 31; b >= 0; b--) begin
        if (nxt[b]) ridx = 5'(b);
      end
      step($sformatf("rand%0d", n), rt, rtv, rrdy, rclr,
           mk(nxt != 0, ridx, nxt != 0, rdone, 6'($countones(nxt))));
      model_tags = nxt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
